// File: rtl/demux_seq_pkg.sv
// demux_seq_pkg: shared channel-count constants and sequencer state type
package demux_seq_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W = 2;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/demux_next_ch.sv
// demux_next_ch: next enabled channel after ptr in order ptr+1..ptr+3 wrapping, else ptr itself
module demux_next_ch
  import demux_seq_pkg::*;
(
  input  logic [CH_W-1:0]   ptr,
  input  logic [NUM_CH-1:0] mask,
  output logic [CH_W-1:0]   nxt,
  output logic              any
);
  logic [CH_W-1:0] c;
  // scan downward so the closest enabled successor wins
  always_comb begin
    nxt = ptr;
    c = ptr;
    for (int k = NUM_CH - 1; k > 0; k--) begin
      c = ptr + CH_W'(k);
      if (mask[c]) nxt = c;
    end
  end
  assign any = |mask;
endmodule

// File: rtl/demux_channel_sequencer.sv
// demux_channel_sequencer: routes serial bits in bursts to rotating demux channels; Ch_mask honoured only with DEMUX_SEQ_SKIP_MASK_EN
module demux_channel_sequencer
  import demux_seq_pkg::*;
#(
  parameter int BURST_LEN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       In_data,
  input  logic       In_valid,
  output logic       In_ready,
  input  logic [3:0] Ch_mask,
  input  logic       Chan_rst,
  output logic       In,
  output logic       S1,
  output logic       S0,
  output logic       Out_valid,
  input  logic       Out_ready
);
  state_t state, state_nx;
  logic [CH_W-1:0] ptr, sel, nxt, low;
  logic [7:0] cnt;
  logic [NUM_CH-1:0] mask;
  logic any, unused_any, acc, last;
`ifdef DEMUX_SEQ_SKIP_MASK_EN
  assign mask = Ch_mask;
`else
  logic unused_mask;
  assign unused_mask = ^Ch_mask;
  assign mask = '1;
`endif
  demux_next_ch u_next (.ptr(ptr), .mask(mask), .nxt(nxt), .any(any));
  demux_next_ch u_low (.ptr(CH_W'(NUM_CH - 1)), .mask(mask), .nxt(low), .any(unused_any));
  assign acc = In_valid && In_ready;
  assign last = cnt == 8'(BURST_LEN - 1);
  assign {S1, S0} = sel;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // leave IDLE once any channel is enabled; fall back only at a burst boundary with nothing enabled
  always_comb
    state_nx = (state == IDLE) ? (any ? RUN : IDLE)
             : ((acc && last && !Chan_rst && !any) ? IDLE : RUN);
  // accept only while running and the output slot is free or being drained
  always_comb In_ready = (state == RUN) && (!Out_valid || Out_ready);
  // output slot, channel pointer and burst counter
  always_ff @(posedge clk) begin
    if (rst) begin
      In <= 1'b0;
      sel <= '0;
      Out_valid <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      if (acc) begin
        In <= In_data;
        sel <= ptr;
        Out_valid <= 1'b1;
      end else if (Out_ready) Out_valid <= 1'b0;
      if (state == IDLE) begin
        if (any) ptr <= low;
        cnt <= '0;
      end else if (Chan_rst) begin
        ptr <= low;
        cnt <= '0;
      end else if (acc) begin
        cnt <= last ? '0 : cnt + 8'd1;
        if (last) ptr <= nxt;
      end
    end
  end
endmodule

// File: doc/demux_channel_sequencer.md
DEMUX_CHANNEL_SEQUENCER -- requirements
Module: demux_channel_sequencer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 1, bits routed to one channel before advancing (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port In_data  input  1  serial data bit from upstream.
REQ-005 SHALL have port In_valid  input  1  In_data valid.
REQ-006 SHALL have port In_ready  output  1  block accepts In_data this cycle.
REQ-007 SHALL have port Ch_mask  input  4  channel enable, bit n = channel n (S1S0 = n).
REQ-008 SHALL have port Chan_rst  input  1  restart rotation at lowest enabled channel.
REQ-009 SHALL have port In  output  1  registered data bit, drives demux data input.
REQ-010 SHALL have port S1, S0  output  1 each  registered channel select, drives demux select.
REQ-011 SHALL have port Out_valid  output  1  In/S1/S0 hold a valid bit.
REQ-012 SHALL have port Out_ready  input  1  downstream capture stage takes the bit this cycle.

Function
REQ-013 SHALL accept a bit when In_valid && In_ready; Out_valid/In/S1/S0 update on the same clock edge (1-cycle latency).
REQ-014 SHALL drive In_ready = (state == RUN) && (!Out_valid || Out_ready), combinationally.
REQ-015 SHALL clear Out_valid when Out_ready && Out_valid and no new bit accepted; In/S1/S0 SHALL hold while Out_valid && !Out_ready.
REQ-016 SHALL keep a 2-bit channel pointer and a burst counter; each accepted bit increments the counter.
REQ-017 SHALL, when burst counter reaches BURST_LEN, reset counter to 0 and move pointer to next enabled channel in order n+1, wrapping 3->0; if only current channel is enabled, pointer stays.
REQ-018 SHALL sample Ch_mask only at burst boundaries; masking the current channel mid-burst SHALL NOT cut the burst.
REQ-019 SHALL implement FSM IDLE/RUN: IDLE->RUN when Ch_mask != 0 (pointer loaded with lowest enabled channel); RUN->IDLE at burst boundary when Ch_mask == 0.
REQ-020 SHALL, on Chan_rst, set pointer to lowest enabled channel and burst counter to 0 next cycle; a bit accepted in the same cycle SHALL use the pre-Chan_rst channel.
REQ-021 SHALL, in IDLE, keep In_ready = 0 while still draining any pending Out_valid via Out_ready.

Reset
REQ-022 SHALL on rst force In=0, S1=0, S0=0, Out_valid=0, pointer=0, burst counter=0, state=IDLE, In_ready=0.
REQ-023 SHALL discard any pending output bit when rst asserts mid-burst; rst SHALL override Chan_rst and handshakes.

Configuration
REQ-024 SHALL honour Ch_mask only when macro DEMUX_SEQ_SKIP_MASK_EN is defined.
REQ-025 SHALL, without DEMUX_SEQ_SKIP_MASK_EN, ignore Ch_mask and treat all four channels as enabled (plain 0->1->2->3 rotation, IDLE exited one cycle after reset).

Structure
REQ-026 SHALL place state enum (IDLE, RUN), NUM_CH = 4 and CH_W = 2 in shared package demux_seq_pkg.
REQ-027 SHALL implement the next-enabled-channel search as sub-module demux_next_ch (inputs pointer, mask; outputs next pointer, any-enabled flag), purely combinational.

Verification
REQ-028 SHALL test BURST_LEN=1, mask 4'b1111, Out_ready=1, bits 1,0,1,1 -> S1S0 = 00,01,10,11 with In = 1,0,1,1, then wrap to 00.
REQ-029 SHALL test BURST_LEN=3, mask 4'b0101, 6 bits -> three bits on channel 0, three on channel 2, then channel 0.
REQ-030 SHALL test Out_ready=0 for 4 cycles with In_valid=1 -> In_ready=0 after first accept, In/S1/S0 stable, no bit lost or duplicated.
REQ-031 SHALL test mask 4'b0000 after reset -> In_ready stays 0, Out_valid 0; set mask 4'b1000 -> first bit on S1S0=11.
REQ-032 SHALL test Chan_rst with accept on channel 2 (mask 4'b0110) -> that bit on S1S0=10, next bit on S1S0=01.
REQ-033 SHALL test rst mid-burst with Out_valid=1 -> next cycle all outputs 0, Out_valid 0, state IDLE.
